// File: rtl/cascade_sequencer_pkg.sv
// Shared constants, types and helpers for the cascade window sequencer.
// Holds frame geometry, per-stage thresholds, the FSM state set and the detection record.
package cascade_pkg;

    localparam int W_STDDEV       = 36;
    localparam int W_SUM          = 18;
    localparam int N_STAGES       = 25;
    localparam int IMG_WIDTH      = 41;
    localparam int IMG_HEIGHT     = 50;
    localparam int FEATURE_WIDTH  = 25;
    localparam int FEATURE_HEIGHT = 25;

    localparam int N_WX    = IMG_WIDTH - FEATURE_WIDTH + 1;
    localparam int N_WY    = IMG_HEIGHT - FEATURE_HEIGHT + 1;
    localparam int W_STAGE = $clog2(N_STAGES);
    localparam int W_X     = $clog2(N_WX);
    localparam int W_Y     = $clog2(N_WY);

    // Thresholds are narrower than the stage sum; the compare widens both operands.
    localparam int W_THR = 16;
    localparam int W_CMP = (W_SUM > W_THR) ? W_SUM : W_THR;

    localparam logic [W_STDDEV-1:0] MIN_STDDEV = 36'd1000;

    localparam logic signed [W_THR-1:0] STAGE_THR [N_STAGES] = '{
        -16'sd120,  -16'sd80,   -16'sd50,   16'sd0,     16'sd35,
         16'sd70,    16'sd110,   16'sd150,  -16'sd200,   16'sd260,
         16'sd300,  -16'sd310,   16'sd400,   16'sd455,   16'sd512,
        -16'sd600,   16'sd700,   16'sd800,   16'sd950,   16'sd1024,
        -16'sd1500,  16'sd2047,  16'sd4000, -16'sd8000,  16'sd16000
    };

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_SD  = 3'd1,
        S_ISSUE    = 3'd2,
        S_WAIT_SUM = 3'd3,
        S_RELEASE  = 3'd4,
        S_REPORT   = 3'd5,
        S_DONE     = 3'd6
    } state_e;

    typedef struct packed {
        logic [W_X-1:0]     x;
        logic [W_Y-1:0]     y;
        logic               hit;
        logic [W_STAGE-1:0] stage;
    } det_t;

    // A stage passes when its sum is at or above the threshold (two's complement).
    function automatic logic stage_pass(input logic signed [W_SUM-1:0] sum,
                                        input logic signed [W_THR-1:0] thr);
        logic signed [W_CMP-1:0] sum_x;
        logic signed [W_CMP-1:0] thr_x;
        sum_x = W_CMP'(sum);
        thr_x = W_CMP'(thr);
        return (sum_x >= thr_x);
    endfunction

endpackage

// File: rtl/cascade_sequencer_if.sv
// Handshake bundle between the sequencer (master) and the stddev, classifier,
// window-buffer and result-consumer peers (slave).
interface cascade_sequencer_if;
    import cascade_pkg::*;

    logic                      stddev_valid;
    logic                      stddev_ready;
    logic [W_STDDEV-1:0]       stddev_data;

    logic                      stage_valid;
    logic                      stage_ready;
    logic [W_STAGE-1:0]        stage_data;

    logic                      sum_valid;
    logic                      sum_ready;
    logic signed [W_SUM-1:0]   sum_data;

    logic                      release_valid;
    logic                      release_ready;

    logic                      det_valid;
    logic                      det_ready;
    logic [W_X-1:0]            det_x;
    logic [W_Y-1:0]            det_y;
    logic                      det_hit;
    logic [W_STAGE-1:0]        det_stage;

    modport master (
        input  stddev_valid, stddev_data,
        output stddev_ready,
        output stage_valid, stage_data,
        input  stage_ready,
        input  sum_valid, sum_data,
        output sum_ready,
        output release_valid,
        input  release_ready,
        output det_valid, det_x, det_y, det_hit, det_stage,
        input  det_ready
    );

    modport slave (
        output stddev_valid, stddev_data,
        input  stddev_ready,
        input  stage_valid, stage_data,
        output stage_ready,
        output sum_valid, sum_data,
        input  sum_ready,
        input  release_valid,
        output release_ready,
        input  det_valid, det_x, det_y, det_hit, det_stage,
        output det_ready
    );

endinterface

// File: rtl/cascade_sequencer_win_pos_cnt.sv
// Raster-order window origin counter: x runs fastest, y advances when x wraps.
// Shared with the multi-scale driver, so geometry is fully parameterised.
module win_pos_cnt #(
    parameter int N_WX = 17,
    parameter int N_WY = 26,
    parameter int W_X  = 5,
    parameter int W_Y  = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           inc,
    output logic [W_X-1:0] x,
    output logic [W_Y-1:0] y,
    output logic           last
);

    localparam logic [W_X-1:0] X_MAX = W_X'(N_WX - 1);
    localparam logic [W_Y-1:0] Y_MAX = W_Y'(N_WY - 1);

    logic [W_X-1:0] x_q, x_d;
    logic [W_Y-1:0] y_q, y_d;

    // Next position: clear wins over increment; both axes wrap at their limits.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr) begin
            x_d = '0;
            y_d = '0;
        end else if (inc) begin
            if (x_q == X_MAX) begin
                x_d = '0;
                if (y_q == Y_MAX) begin
                    y_d = '0;
                end else begin
                    y_d = y_q + W_Y'(1);
                end
            end else begin
                x_d = x_q + W_X'(1);
            end
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
    end

    // Position registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/cascade_sequencer.sv
// Window-level cascade controller: gates each window on its stddev, walks the
// classifier stages until one fails, releases the buffer and reports the result.
module cascade_sequencer (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    cascade_sequencer_if.master bus
);
    import cascade_pkg::*;

    localparam logic [2:0] ST_IDLE     = S_IDLE;
    localparam logic [2:0] ST_WAIT_SD  = S_WAIT_SD;
    localparam logic [2:0] ST_ISSUE    = S_ISSUE;
    localparam logic [2:0] ST_WAIT_SUM = S_WAIT_SUM;
    localparam logic [2:0] ST_RELEASE  = S_RELEASE;
    localparam logic [2:0] ST_REPORT   = S_REPORT;
    localparam logic [2:0] ST_DONE     = S_DONE;

    localparam logic [W_STAGE-1:0] LAST_STAGE = W_STAGE'(N_STAGES - 1);

    logic [2:0]         state_q, state_d;
    logic [W_STAGE-1:0] stage_q, stage_d;
    logic               hit_q, hit_d;

    logic stddev_ready_q;
    logic stage_valid_q;
    logic sum_ready_q;
    logic release_valid_q;
    logic det_valid_q;
    logic busy_q;
    logic done_q;

    logic sd_hs_s, stage_hs_s, sum_hs_s, rel_hs_s, det_hs_s;
    logic flat_s, pass_s, cnt_clr_s, last_s;
    logic [W_X-1:0] x_s;
    logic [W_Y-1:0] y_s;
    det_t           det_s;

    assign sd_hs_s    = bus.stddev_valid  && stddev_ready_q;
    assign stage_hs_s = stage_valid_q     && bus.stage_ready;
    assign sum_hs_s   = bus.sum_valid     && sum_ready_q;
    assign rel_hs_s   = release_valid_q   && bus.release_ready;
    assign det_hs_s   = det_valid_q       && bus.det_ready;

    assign flat_s    = (bus.stddev_data < MIN_STDDEV);
    assign pass_s    = stage_pass(bus.sum_data, STAGE_THR[stage_q]);
    assign cnt_clr_s = (state_q == ST_IDLE);

    win_pos_cnt #(
        .N_WX (N_WX),
        .N_WY (N_WY),
        .W_X  (W_X),
        .W_Y  (W_Y)
    ) u_pos (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr_s),
        .inc  (det_hs_s),
        .x    (x_s),
        .y    (y_s),
        .last (last_s)
    );

    // Window FSM: next state plus the stage index and hit flag being built up.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        hit_d   = hit_q;
        case (state_q)
            ST_IDLE: begin
                stage_d = '0;
                hit_d   = 1'b0;
                if (start) begin
                    state_d = ST_WAIT_SD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_SD: begin
                if (sd_hs_s) begin
                    stage_d = '0;
                    if (flat_s) begin
                        hit_d   = 1'b0;
                        state_d = ST_RELEASE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_WAIT_SD;
                end
            end
            ST_ISSUE: begin
                if (stage_hs_s) begin
                    state_d = ST_WAIT_SUM;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT_SUM: begin
                if (sum_hs_s) begin
                    if (!pass_s) begin
                        hit_d   = 1'b0;
                        state_d = ST_RELEASE;
                    end else if (stage_q == LAST_STAGE) begin
                        hit_d   = 1'b1;
                        state_d = ST_RELEASE;
                    end else begin
                        stage_d = stage_q + W_STAGE'(1);
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_WAIT_SUM;
                end
            end
            ST_RELEASE: begin
                if (rel_hs_s) begin
                    state_d = ST_REPORT;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            ST_REPORT: begin
                // last_s still reflects the window being reported this cycle.
                if (det_hs_s) begin
                    if (last_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT_SD;
                    end
                end else begin
                    state_d = ST_REPORT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and handshake flags; flags are registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            stage_q         <= '0;
            hit_q           <= 1'b0;
            stddev_ready_q  <= 1'b0;
            stage_valid_q   <= 1'b0;
            sum_ready_q     <= 1'b0;
            release_valid_q <= 1'b0;
            det_valid_q     <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            stage_q         <= stage_d;
            hit_q           <= hit_d;
            stddev_ready_q  <= (state_d == ST_WAIT_SD);
            stage_valid_q   <= (state_d == ST_ISSUE);
            sum_ready_q     <= (state_d == ST_WAIT_SUM);
            release_valid_q <= (state_d == ST_RELEASE);
            det_valid_q     <= (state_d == ST_REPORT);
            busy_q          <= (state_d != ST_IDLE);
            done_q          <= (state_d == ST_DONE);
        end
    end

    assign det_s = '{x: x_s, y: y_s, hit: hit_q, stage: stage_q};

    assign busy              = busy_q;
    assign done              = done_q;
    assign bus.stddev_ready  = stddev_ready_q;
    assign bus.stage_valid   = stage_valid_q;
    assign bus.stage_data    = stage_q;
    assign bus.sum_ready     = sum_ready_q;
    assign bus.release_valid = release_valid_q;
    assign bus.det_valid     = det_valid_q;
    assign bus.det_x         = det_s.x;
    assign bus.det_y         = det_s.y;
    assign bus.det_hit       = det_s.hit;
    assign bus.det_stage     = det_s.stage;

endmodule

// File: tb/tb_cascade_sequencer.sv
// Directed-plus-random bench for cascade_sequencer: plays the stddev, classifier,
// buffer and consumer peers and checks each window against a stage-walk model.
module tb_cascade_sequencer;

    localparam int NWX  = 17;
    localparam int NWY  = 26;
    localparam int NWIN = NWX * NWY;
    localparam int NST  = 25;
    localparam logic [35:0] MIN_SD = 36'd1000;

    int thr [NST] = '{ -120,  -80,  -50,    0,   35,
                         70,  110,  150, -200,  260,
                        300, -310,  400,  455,  512,
                       -600,  700,  800,  950, 1024,
                      -1500, 2047, 4000, -8000, 16000 };

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;

    int n_cmp  = 0;
    int n_err  = 0;
    int bp_max = 0;
    int sums [NST];

    cascade_sequencer_if bus_if ();

    cascade_sequencer dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // 0 stddev_ready, 1 stage_valid, 2 sum_ready, 3 release_valid, 4 det_valid
    function automatic logic sig(input int which);
        case (which)
            0: return bus_if.stddev_ready;
            1: return bus_if.stage_valid;
            2: return bus_if.sum_ready;
            3: return bus_if.release_valid;
            4: return bus_if.det_valid;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] dat(input int which);
        if (which == 1) return 64'(bus_if.stage_data);
        return 64'({bus_if.det_x, bus_if.det_y, bus_if.det_hit, bus_if.det_stage});
    endfunction

    // Expected outcome of one window from the cascade rules.
    function automatic void model(input logic [35:0] sd, output bit hit, output int stg,
                                  output int iss);
        hit = 1'b0; stg = 0; iss = 0;
        if (sd >= MIN_SD) begin
            hit = 1'b1; stg = NST - 1; iss = NST;
            for (int k = 0; k < NST; k++) begin
                if (sums[k] < thr[k]) begin
                    hit = 1'b0; stg = k; iss = k + 1;
                    break;
                end
            end
        end
    endfunction

    task automatic wait_sig(input int which, input string tag);
        for (int i = 0; i < 60; i++) begin
            if (sig(which)) break;
            @(negedge clk);
        end
        check({tag, " wait"}, 64'(sig(which)), 64'd1);
    endtask

    task automatic stall(input int which, input string tag);
        logic [63:0] snap;
        int n;
        snap = (which == 3) ? 64'd0 : dat(which);
        n = int'($urandom_range(0, bp_max));
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, " valid held"}, 64'(sig(which)), 64'd1);
            if (which != 3) check({tag, " data held"}, dat(which), snap);
        end
    endtask

    task automatic accept(input int which, input string tag);
        if (which == 1) bus_if.stage_ready = 1'b1;
        else if (which == 3) bus_if.release_ready = 1'b1;
        else bus_if.det_ready = 1'b1;
        @(negedge clk);
        bus_if.stage_ready = 1'b0; bus_if.release_ready = 1'b0; bus_if.det_ready = 1'b0;
        check({tag, " valid dropped"}, 64'(sig(which)), 64'd0);
    endtask

    task automatic produce(input int which, input logic [63:0] val, input string tag);
        repeat ($urandom_range(0, bp_max)) @(negedge clk);
        if (which == 0) begin
            bus_if.stddev_data = val[35:0]; bus_if.stddev_valid = 1'b1;
        end else begin
            bus_if.sum_data = val[17:0]; bus_if.sum_valid = 1'b1;
        end
        wait_sig(which, tag);
        @(negedge clk);
        bus_if.stddev_valid = 1'b0; bus_if.sum_valid = 1'b0;
        check({tag, " ready dropped"}, 64'(sig(which)), 64'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_window(input int idx, input logic [35:0] sd, input bit last_win);
        bit ehit; int estg; int eiss; int iss;
        model(sd, ehit, estg, eiss);
        produce(0, 64'(sd), "stddev");
        iss = 0;
        for (int g = 0; g < NST + 2; g++) begin
            for (int i = 0; i < 60 && !bus_if.stage_valid && !bus_if.release_valid; i++)
                @(negedge clk);
            if (!bus_if.stage_valid) break;
            check("stage index", 64'(bus_if.stage_data), 64'(iss));
            stall(1, "stage");
            accept(1, "stage");
            produce(2, 64'((iss < NST) ? sums[iss] : 0), "sum");
            iss++;
        end
        check("issue count", 64'(iss), 64'(eiss));
        check("release valid", 64'(bus_if.release_valid), 64'd1);
        stall(3, "release");
        accept(3, "release");
        wait_sig(4, "det");
        check("det x", 64'(bus_if.det_x), 64'(idx % NWX));
        check("det y", 64'(bus_if.det_y), 64'(idx / NWX));
        check("det hit", 64'(bus_if.det_hit), 64'(ehit));
        check("det stage", 64'(bus_if.det_stage), 64'(estg));
        stall(4, "det");
        accept(4, "det");
        check("done after det", 64'(done), 64'(last_win));
        if (last_win) begin
            @(negedge clk);
            check("done single", 64'(done), 64'd0);
            check("busy after done", 64'(busy), 64'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " done"}, 64'(done), 64'd0);
        check({tag, " stddev_ready"}, 64'(bus_if.stddev_ready), 64'd0);
        check({tag, " stage_valid"}, 64'(bus_if.stage_valid), 64'd0);
        check({tag, " stage_data"}, 64'(bus_if.stage_data), 64'd0);
        check({tag, " sum_ready"}, 64'(bus_if.sum_ready), 64'd0);
        check({tag, " release_valid"}, 64'(bus_if.release_valid), 64'd0);
        check({tag, " det_valid"}, 64'(bus_if.det_valid), 64'd0);
        check({tag, " det_xyhs"}, dat(4), 64'd0);
    endtask

    initial begin
        logic [35:0] sd;
        int r;
        bus_if.stddev_valid = 1'b0; bus_if.stddev_data = '0;
        bus_if.stage_ready = 1'b0; bus_if.sum_valid = 1'b0; bus_if.sum_data = '0;
        bus_if.release_ready = 1'b0; bus_if.det_ready = 1'b0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        check("idle busy", 64'(busy), 64'd0);
        pulse_start();
        check("start busy", 64'(busy), 64'd1);
        check("start stddev_ready", 64'(bus_if.stddev_ready), 64'd1);

        // Frame 1: directed boundaries, then random back-pressure, then flat tail.
        run_window(0, MIN_SD - 36'd1, 1'b0);
        sums[0] = thr[0] - 1;
        run_window(1, 36'd5000, 1'b0);
        for (int k = 0; k < NST; k++) sums[k] = thr[k];
        run_window(2, MIN_SD, 1'b0);

        bp_max = 3;
        for (int idx = 3; idx < 50; idx++) begin
            for (int k = 0; k < NST; k++) sums[k] = thr[k] + int'($urandom_range(0, 30)) - 1;
            r = int'($urandom_range(0, 5));
            case (r)
                0: sd = 36'($urandom_range(0, 999));
                1: sd = MIN_SD;
                2: sd = MIN_SD - 36'd1;
                3: sd = {4'hF, 32'($urandom)};
                default: sd = 36'($urandom_range(1000, 1000000));
            endcase
            if (idx == 20) pulse_start();
            run_window(idx, sd, 1'b0);
        end

        bp_max = 0;
        for (int idx = 50; idx < NWIN; idx++) run_window(idx, 36'd0, idx == NWIN - 1);

        // Frame 2: reset while window 7 waits for its first stage sum.
        pulse_start();
        for (int idx = 0; idx < 7; idx++) run_window(idx, 36'd0, 1'b0);
        produce(0, 64'd5000, "stddev");
        wait_sig(1, "stage");
        accept(1, "stage");
        wait_sig(2, "sum");
        rst = 1'b0;
        #1;
        check_all_zero("midframe reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post reset busy", 64'(busy), 64'd0);
        for (int k = 0; k < NST; k++) sums[k] = thr[k];
        pulse_start();
        run_window(0, 36'd2000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
